// File: rtl/multdiv_sequencer.sv
// multdiv_sequencer
//   Issues mul/div operations decoded in the execute stage to a shared multi-cycle
//   unit. It stalls F/D/X while the unit works, then presents the result (or an
//   rstatus exception code) for one cycle to the X/M latch. A watchdog aborts a
//   unit that never answers.
// Ports
//   clock, reset_n                 rising-edge clock, async active-low reset
//   ir_x, valid_x, flush           X-stage instruction, its valid bit, branch kill
//   md_ready/md_exception/md_result  unit completion handshake
//   ctrl_mult, ctrl_div            one-cycle start pulses to the unit
//   stall                          hold F/D/X
//   wb_valid, wb_rd, wb_data       writeback request for the X/M latch
//   busy, timeout_err              status: not idle / sticky watchdog abort
module multdiv_sequencer #(
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned TIMEOUT     = 40,
    parameter int unsigned RSTATUS_REG = 30,
    parameter int unsigned MUL_EXC     = 4,
    parameter int unsigned DIV_EXC     = 5
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic [31:0]       ir_x,
    input  logic              valid_x,
    input  logic              flush,
    input  logic              md_ready,
    input  logic              md_exception,
    input  logic [DATA_W-1:0] md_result,
    output logic              ctrl_mult,
    output logic              ctrl_div,
    output logic              stall,
    output logic              wb_valid,
    output logic [4:0]        wb_rd,
    output logic [DATA_W-1:0] wb_data,
    output logic              busy,
    output logic              timeout_err
);

    localparam int unsigned CNT_W   = $clog2(TIMEOUT);
    localparam logic [4:0]  OPC_MD  = 5'b00000;
    localparam logic [4:0]  ALU_MUL = 5'b00110;
    localparam logic [4:0]  ALU_DIV = 5'b00111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                op_div_q, op_div_d;
    logic [4:0]          rd_q, rd_d;
    logic [4:0]          wb_rd_q, wb_rd_d;
    logic [DATA_W-1:0]   wb_data_q, wb_data_d;
    logic                timeout_err_q, timeout_err_d;

    logic dec_mul, dec_div, is_md;

    // Only opcode, rd and ALU op fields take part in decode.
    logic unused_ir;
    assign unused_ir = ^{ir_x[21:7], ir_x[1:0]};

    // Decode; reset_n gating makes the start pulses and stall drop asynchronously.
    assign dec_mul = (ir_x[31:27] == OPC_MD) && (ir_x[6:2] == ALU_MUL);
    assign dec_div = (ir_x[31:27] == OPC_MD) && (ir_x[6:2] == ALU_DIV);
    assign is_md   = reset_n & valid_x & ~flush & (dec_mul | dec_div);

    // Next-state and outputs.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        op_div_d      = op_div_q;
        rd_d          = rd_q;
        wb_rd_d       = wb_rd_q;
        wb_data_d     = wb_data_q;
        timeout_err_d = timeout_err_q;
        ctrl_mult     = 1'b0;
        ctrl_div      = 1'b0;
        stall         = 1'b0;
        wb_valid      = 1'b0;

        case (state_q)
            IDLE: begin
                if (is_md) begin
                    ctrl_mult = ~dec_div;
                    ctrl_div  = dec_div;
                    stall     = 1'b1;
                    op_div_d  = dec_div;
                    rd_d      = ir_x[26:22];
                    cnt_d     = '0;
                    state_d   = BUSY;
                end
            end
            BUSY: begin
                stall = 1'b1;
                cnt_d = cnt_q + CNT_W'(1);
                if (flush) begin
                    state_d = IDLE;
                end else if (md_ready && !md_exception) begin
                    wb_rd_d   = rd_q;
                    wb_data_d = md_result;
                    state_d   = DONE;
                end else if (md_ready) begin
                    wb_rd_d   = 5'(RSTATUS_REG);
                    wb_data_d = op_div_q ? DATA_W'(DIV_EXC) : DATA_W'(MUL_EXC);
                    state_d   = DONE;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    wb_rd_d       = 5'(RSTATUS_REG);
                    wb_data_d     = DATA_W'(DIV_EXC);
                    timeout_err_d = 1'b1;
                    state_d       = DONE;
                end
            end
            DONE: begin
                // The finished op is still in ir_x here, so no decode.
                wb_valid = ~flush;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            op_div_q      <= 1'b0;
            rd_q          <= '0;
            wb_rd_q       <= '0;
            wb_data_q     <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            op_div_q      <= op_div_d;
            rd_q          <= rd_d;
            wb_rd_q       <= wb_rd_d;
            wb_data_q     <= wb_data_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign busy        = (state_q != IDLE);
    assign wb_rd       = wb_rd_q;
    assign wb_data     = wb_data_q;
    assign timeout_err = timeout_err_q;

endmodule
